// File: rtl/simon_pkg.sv
// Types shared by the Simon game controller, pattern player and VGA driver.
// Colour codes match the driver's full-screen colour encoding.
package simon_pkg;

   typedef enum logic [1:0] {
      COL_RED   = 2'b00,
      COL_GREEN = 2'b01,
      COL_BLUE  = 2'b10,
      COL_CYAN  = 2'b11
   } color_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } player_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width with a floor of one bit so tiny parameters still elaborate.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/simon_pattern_ram.sv
// Pattern store: DEPTH x 2-bit, synchronous write, asynchronous read, no reset.
// Writes at or beyond DEPTH are dropped; out-of-range reads return red.
module simon_pattern_ram
   import simon_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [1:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [1:0]    rdata_o
);

   logic [1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i && (int'(waddr_i) < DEPTH)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = COL_RED;
      if (int'(raddr_i) < DEPTH) begin
         rdata_o = mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/simon_pattern_player.sv
// Plays the stored Simon sequence: each step shows a colour for ON_CYCLES, then blanks for OFF_CYCLES.
// First en one cycle after start; all outputs registered; pattern writes are ignored while busy.
module simon_pattern_player
   import simon_pkg::*;
#(
   parameter int MAX_LEN    = 16,
   parameter int ON_CYCLES  = 25_000_000,
   parameter int OFF_CYCLES = 12_500_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [$clog2(MAX_LEN)-1:0]   wr_addr,
   input  logic [1:0]                   wr_color,
   input  logic                         start,
   input  logic [$clog2(MAX_LEN+1)-1:0] seq_len,
   input  logic                         abort,
   output logic                         en,
   output logic [1:0]                   color,
   output logic                         busy,
   output logic                         done
);

   localparam int IW = $clog2(MAX_LEN);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = width_of(max_int(ON_CYCLES, OFF_CYCLES));

   player_state_t state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [LW-1:0] len_q, len_d;
   logic          en_q, en_d;
   logic [1:0]    color_q, color_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          start_ok;
   logic          last_on;
   logic          last_off;
   logic          last_step;
   logic          ram_we;
   logic [1:0]    ram_rdata;

   assign start_ok  = start && (seq_len != '0) && (seq_len <= LW'(MAX_LEN));
   assign last_on   = (timer_q == TW'(ON_CYCLES - 1));
   assign last_off  = (timer_q == TW'(OFF_CYCLES - 1));
   assign last_step = (LW'(idx_q) == (len_q - LW'(1)));
   // Pattern is frozen during SHOW/GAP so the sequence cannot change mid-playback.
   assign ram_we    = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   simon_pattern_ram #(
      .DEPTH (MAX_LEN),
      .AW    (IW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wr_addr),
      .wdata_i (wr_color),
      .raddr_i (idx_d),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TW'(1);
      idx_d   = idx_q;
      len_d   = len_q;

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (start_ok && !abort) begin
               state_d = ST_SHOW;
               len_d   = seq_len;
               idx_d   = '0;
            end
         end
         ST_SHOW: begin
            if (last_on) begin
               state_d = ST_GAP;
               timer_d = '0;
            end
         end
         ST_GAP: begin
            if (last_off) begin
               timer_d = '0;
               if (last_step) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHOW;
                  idx_d   = idx_q + IW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end

      // Outputs are registered from the next state so they line up with it.
      en_d    = (state_d == ST_SHOW);
      color_d = en_d ? ram_rdata : 2'b00;
      busy_d  = (state_d == ST_SHOW) || (state_d == ST_GAP);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         en_q    <= 1'b0;
         color_q <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         en_q    <= en_d;
         color_q <= color_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign en    = en_q;
   assign color = color_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_simon_pattern_player.sv
// Directed bench for simon_pattern_player with ON=4, OFF=2, MAX_LEN=16.
module tb_simon_pattern_player;
   import simon_pkg::*;

   localparam int MAX_LEN = 16;
   localparam int ON      = 4;
   localparam int OFF     = 2;
   localparam int STEP    = ON + OFF;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [1:0] wr_color = '0;
   logic       start = 1'b0;
   logic [4:0] seq_len = '0;
   logic       abort = 1'b0;
   logic       en;
   logic [1:0] color;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_ram [MAX_LEN];

   typedef struct {
      logic       start;
      logic [4:0] len;
      logic       abort;
      logic       en;
      logic [1:0] col;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl [20];

   always #5 clk = ~clk;

   simon_pattern_player #(
      .MAX_LEN    (MAX_LEN),
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_color (wr_color),
      .start    (start),
      .seq_len  (seq_len),
      .abort    (abort),
      .en       (en),
      .color    (color),
      .busy     (busy),
      .done     (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input int cyc, input logic e_en,
                             input logic [1:0] e_col, input logic e_busy, input logic e_done);
      chk({name, ".en"},    cyc, 32'(en),    32'(e_en));
      chk({name, ".color"}, cyc, 32'(color), 32'(e_col));
      chk({name, ".busy"},  cyc, 32'(busy),  32'(e_busy));
      chk({name, ".done"},  cyc, 32'(done),  32'(e_done));
   endtask

   task automatic wr(input int addr, input logic [1:0] col);
      wr_en    = 1'b1;
      wr_addr  = 4'(addr);
      wr_color = col;
      tick();
      wr_en    = 1'b0;
      exp_ram[addr] = col;
   endtask

   // Start a run and check every cycle against the timing model; optionally
   // inject a start pulse plus a write to ram[1] while playback is running.
   task automatic play(input string name, input int len, input int ncyc, input int inj_cyc);
      logic       e_en, e_busy, e_done;
      logic [1:0] e_col;
      int         stp, ph;
      seq_len = 5'(len);
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         stp = (c - 1) / STEP;
         ph  = (c - 1) % STEP;
         e_en = 1'b0; e_col = 2'b00; e_busy = 1'b0; e_done = 1'b0;
         if (stp < len) begin
            e_busy = 1'b1;
            e_en   = (ph < ON);
            e_col  = e_en ? exp_ram[stp] : 2'b00;
         end else if (c == 1 + len * STEP) begin
            e_done = 1'b1;
         end
         check_outs(name, c, e_en, e_col, e_busy, e_done);
         if (c == inj_cyc) begin
            start    = 1'b1;
            seq_len  = 5'd1;
            wr_en    = 1'b1;
            wr_addr  = 4'd1;
            wr_color = COL_GREEN;
         end
         tick();
         start = 1'b0;
         wr_en = 1'b0;
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check_outs("reset", 0, 1'b0, 2'b00, 1'b0, 1'b0);
      rst = 1'b1;
      tick();

      // Test 1: table-driven len=3 playback of RED, BLUE, CYAN
      wr(0, COL_RED);
      wr(1, COL_BLUE);
      wr(2, COL_CYAN);
      for (int r = 0; r < 20; r++) begin
         int c;
         c = r + 1;
         tbl[r] = '{start: (r == 0), len: 5'd3, abort: 1'b0,
                    en: 1'b0, col: 2'b00, busy: 1'b0, done: 1'b0};
         if (c >= 1 && c <= 18)   tbl[r].busy = 1'b1;
         if (c >= 1 && c <= 4)    begin tbl[r].en = 1'b1; tbl[r].col = 2'b00; end
         if (c >= 7 && c <= 10)   begin tbl[r].en = 1'b1; tbl[r].col = 2'b10; end
         if (c >= 13 && c <= 16)  begin tbl[r].en = 1'b1; tbl[r].col = 2'b11; end
         if (c == 19)             tbl[r].done = 1'b1;
      end
      for (int r = 0; r < 20; r++) begin
         start   = tbl[r].start;
         seq_len = tbl[r].len;
         abort   = tbl[r].abort;
         tick();
         check_outs("t1", r + 1, tbl[r].en, tbl[r].col, tbl[r].busy, tbl[r].done);
      end
      start = 1'b0;
      abort = 1'b0;

      // Test 4: start pulse and ram[1] write during playback are both ignored
      play("t4_run", 3, 20, 2);
      play("t4_replay", 3, 20, 0);

      // Test 2: illegal lengths are ignored
      seq_len = 5'd0;  start = 1'b1; tick();
      check_outs("t2_len0", 1, 1'b0, 2'b00, 1'b0, 1'b0);
      seq_len = 5'd17; start = 1'b1; tick();
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         check_outs("t2_len17", c, 1'b0, 2'b00, 1'b0, 1'b0);
         tick();
      end

      // abort and start together in IDLE: abort wins, nothing starts
      seq_len = 5'd3; start = 1'b1; abort = 1'b1; tick();
      start = 1'b0; abort = 1'b0;
      check_outs("abort_start", 1, 1'b0, 2'b00, 1'b0, 1'b0);
      tick();

      // Test 3: abort during the first gap
      seq_len = 5'd3; start = 1'b1; tick();
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (c == 6) begin
            check_outs("t3_pre", c, 1'b0, 2'b00, 1'b1, 1'b0);
            abort = 1'b1;
         end
         tick();
      end
      abort = 1'b0;
      check_outs("t3_abort", 7, 1'b0, 2'b00, 1'b0, 1'b0);
      for (int c = 8; c <= 22; c++) begin
         tick();
         chk("t3_nodone", c, 32'(done), 32'd0);
         chk("t3_idle", c, 32'(busy), 32'd0);
      end

      // Test 5: synchronous reset mid-run, then a len=1 run
      seq_len = 5'd3; start = 1'b1; tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) begin
            check_outs("t5_pre", c, 1'b1, 2'b10, 1'b1, 1'b0);
            rst = 1'b0;
         end
         tick();
      end
      check_outs("t5_rst", 9, 1'b0, 2'b00, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      play("t5_len1", 1, 8, 0);

      // Test 6: full-depth playback
      for (int i = 0; i < MAX_LEN; i++) wr(i, 2'(i % 4));
      play("t6_len16", 16, 98, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
